// File: rtl/dds_freq_meter.sv
// Frequency meter for a signed sample stream. It times NCYC periods between
// hysteresis zero crossings and divides to get the equivalent DDS tuning word.
module dds_freq_meter #(
   parameter int M    = 16,
   parameter int W    = 16,
   parameter int NCYC = 4,
   parameter int CW   = 24,
   parameter int HYST = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] sample_in,
   input  logic         val_in,
   input  logic         start,
   output logic [M-1:0] P_est,
   output logic         val_out,
   output logic         busy,
   output logic         ovf
);

   localparam int SW = $clog2(M + 1);
   localparam int RW = CW + 1;
   localparam logic signed [W-1:0] HYST_POS = W'(HYST);
   localparam logic signed [W-1:0] HYST_NEG = -HYST_POS;
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [RW-1:0] NCYC_R    = RW'(NCYC);
   localparam logic [M-1:0]  NCYC_X    = M'(NCYC);
   localparam logic [SW-1:0] LAST_STEP = SW'(M - 1);

   typedef enum logic [2:0] {IDLE, SEEK, COUNT, DIV, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [M-1:0]  xcnt_q, xcnt_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] t_q, t_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [M-1:0]  quo_q, quo_d;
   logic [SW-1:0] step_q, step_d;
   logic [M-1:0]  p_est_q, p_est_d;
   logic          ovf_q, ovf_d;
   logic          val_out_q, val_out_d;

   logic          is_low;
   logic          is_high;
   logic          crossing;
   logic [RW-1:0] rem_sh;
   logic          rem_ge;

   // Rising crossing needs a prior sample at or below -HYST, so noise smaller
   // than HYST around zero can never produce a second crossing.
   assign is_low   = $signed(sample_in) <= HYST_NEG;
   assign is_high  = $signed(sample_in) >= HYST_POS;
   assign crossing = val_in && armed_q && is_high;

   // The remainder stays below T, so doubling it always fits in CW+1 bits.
   assign rem_sh = rem_q << 1;
   assign rem_ge = rem_sh >= {1'b0, t_q};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      xcnt_d    = xcnt_q;
      armed_d   = armed_q;
      t_d       = t_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      step_d    = step_q;
      p_est_d   = p_est_q;
      ovf_d     = ovf_q;
      val_out_d = 1'b0;

      case (state_q)
         IDLE: begin
            armed_d = 1'b0;
            if (start) begin
               state_d = SEEK;
               cnt_d   = '0;
               xcnt_d  = '0;
            end
         end

         SEEK, COUNT: begin
            if (val_in) begin
               if (cnt_q == CNT_MAX) begin
                  state_d   = DONE;
                  ovf_d     = 1'b1;
                  p_est_d   = '0;
                  val_out_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (crossing) begin
                     armed_d = 1'b0;
                  end else if (is_low) begin
                     armed_d = 1'b1;
                  end
                  if (crossing && (state_q == SEEK)) begin
                     state_d = COUNT;
                     cnt_d   = '0;
                     xcnt_d  = '0;
                  end else if (crossing) begin
                     xcnt_d = xcnt_q + 1'b1;
                     if ((xcnt_q + 1'b1) == NCYC_X) begin
                        state_d = DIV;
                        t_d     = cnt_q + 1'b1;
                        rem_d   = NCYC_R;
                        quo_d   = '0;
                        step_d  = '0;
                     end
                  end
               end
            end
         end

         DIV: begin
            if ({1'b0, t_q} <= NCYC_R) begin
               state_d   = DONE;
               p_est_d   = '1;
               ovf_d     = 1'b0;
               val_out_d = 1'b1;
            end else begin
               rem_d  = rem_ge ? (rem_sh - {1'b0, t_q}) : rem_sh;
               quo_d  = {quo_q[M-2:0], rem_ge};
               step_d = step_q + 1'b1;
               if (step_q == LAST_STEP) begin
                  state_d   = DONE;
                  p_est_d   = {quo_q[M-2:0], rem_ge};
                  ovf_d     = 1'b0;
                  val_out_d = 1'b1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         xcnt_q    <= '0;
         armed_q   <= 1'b0;
         t_q       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         step_q    <= '0;
         p_est_q   <= '0;
         ovf_q     <= 1'b0;
         val_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         xcnt_q    <= xcnt_d;
         armed_q   <= armed_d;
         t_q       <= t_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         step_q    <= step_d;
         p_est_q   <= p_est_d;
         ovf_q     <= ovf_d;
         val_out_q <= val_out_d;
      end
   end

   assign P_est   = p_est_q;
   assign val_out = val_out_q;
   assign ovf     = ovf_q;
   assign busy    = (state_q != IDLE);

endmodule
